// File: rtl/imm_pkg.sv
// Shared encodings for the pipelined immediate generator:
// ImmSrc format codes and the output-buffer occupancy states.
package imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b10
  } occ_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-side and ID/EX-side handshake bundle of the immediate stage.
// "slave" is the stage itself, "master" is the surrounding pipeline.
interface imm_extend_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [24:0]     instruction;
  logic [2:0]      ImmSrc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ImmExt;
  logic            out_illegal;

  modport slave (
    input  in_valid, instruction, ImmSrc, flush, out_ready,
    output in_ready, out_valid, ImmExt, out_illegal
  );

  modport master (
    output in_valid, instruction, ImmSrc, flush, out_ready,
    input  in_ready, out_valid, ImmExt, out_illegal
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction from instruction[31:7]; port bit k
// corresponds to instruction bit k+7.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     i_instr,
  input  logic [2:0]      i_src,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_imm
);

  logic signed [31:0] w_imm32;

  always_comb begin
    w_imm32   = '0;
    o_illegal = 1'b0;
    case (i_src)
      IMM_I:   w_imm32 = {{20{i_instr[24]}}, i_instr[24:13]};
      IMM_S:   w_imm32 = {{20{i_instr[24]}}, i_instr[24:18], i_instr[4:0]};
      IMM_B:   w_imm32 = {{20{i_instr[24]}}, i_instr[0], i_instr[23:18], i_instr[4:1], 1'b0};
      IMM_J:   w_imm32 = {{12{i_instr[24]}}, i_instr[12:5], i_instr[13], i_instr[23:14], 1'b0};
      IMM_U:   w_imm32 = {i_instr[24:5], 12'b0};
      IMM_Z:   w_imm32 = {27'b0, i_instr[12:8]};
      default: o_illegal = 1'b1;
    endcase
  end

  // Signed size cast fills XLEN-1:32 with bit 31; Z and illegal have it clear.
  assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with a valid/ready output buffer: one cycle
// of latency, optional 2-entry skid so in_ready comes straight from a flop.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  imm_extend_pipe_if.slave bus
);

  occ_e            r_state, w_next;
  logic            r_in_ready;
  logic            w_in_ready, w_out_valid, w_accept, w_pop;
  logic [XLEN-1:0] w_dec_imm_p0;
  logic            w_dec_ill_p0;
  logic [XLEN-1:0] r_main_imm_p1, r_skid_imm_p1;
  logic            r_main_ill_p1, r_skid_ill_p1;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instr   (bus.instruction),
    .i_src     (bus.ImmSrc),
    .o_illegal (w_dec_ill_p0),
    .o_imm     (w_dec_imm_p0)
  );

  assign w_out_valid = (r_state != OCC_EMPTY);
  assign w_in_ready  = SKID_EN ? r_in_ready : (!w_out_valid || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      OCC_EMPTY: if (w_accept) w_next = OCC_ONE;
      OCC_ONE: begin
        if (w_accept && !w_pop)      w_next = OCC_FULL;
        else if (w_pop && !w_accept) w_next = OCC_EMPTY;
      end
      OCC_FULL:  if (w_pop) w_next = OCC_ONE;
      default:   w_next = OCC_EMPTY;
    endcase
    if (bus.flush) w_next = OCC_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= OCC_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != OCC_FULL);
    end
  end

  // p0 -> p1: final immediates are captured only on accept; the skid entry
  // is used only when the main entry is still held by the consumer.
  always_ff @(posedge clk) begin
    if (w_accept && (r_state == OCC_EMPTY || (r_state == OCC_ONE && w_pop))) begin
      r_main_imm_p1 <= w_dec_imm_p0;
      r_main_ill_p1 <= w_dec_ill_p0;
    end else if (r_state == OCC_FULL && w_pop) begin
      r_main_imm_p1 <= r_skid_imm_p1;
      r_main_ill_p1 <= r_skid_ill_p1;
    end
    if (w_accept && r_state == OCC_ONE && !w_pop) begin
      r_skid_imm_p1 <= w_dec_imm_p0;
      r_skid_ill_p1 <= w_dec_ill_p0;
    end
  end

  // Data flops are not reset; gating by valid keeps outputs zero and X-free when idle.
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.ImmExt      = w_out_valid ? r_main_imm_p1 : '0;
  assign bus.out_illegal = w_out_valid && r_main_ill_p1;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench: a 32-bit skid instance and a 64-bit single-entry instance.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.XLEN(32)) a ();
  imm_extend_pipe_if #(.XLEN(64)) b ();

  imm_extend_pipe #(.XLEN(32), .SKID_EN(1'b1)) dut32 (.clk(clk), .reset(reset), .bus(a.slave));
  imm_extend_pipe #(.XLEN(64), .SKID_EN(1'b0)) dut64 (.clk(clk), .reset(reset), .bus(b.slave));

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] vals [4];
  int idx, rcv;
  logic acc, pop;
  logic [31:0] popv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat32(input string tag, input logic [24:0] ins, input logic [2:0] src,
                        input logic [31:0] exp, input logic ill);
    a.in_valid = 1'b1; a.instruction = ins; a.ImmSrc = src; a.out_ready = 1'b1;
    step();
    chk({tag, "_valid"}, 64'(a.out_valid), 64'd1);
    chk(tag, 64'(a.ImmExt), 64'(exp));
    chk({tag, "_ill"}, 64'(a.out_illegal), 64'(ill));
    a.in_valid = 1'b0;
    step();
    chk({tag, "_drain"}, 64'(a.out_valid), 64'd0);
  endtask

  initial begin
    vals[0] = 32'h0000_0001; vals[1] = 32'h0000_0002;
    vals[2] = 32'h0000_07FF; vals[3] = 32'hFFFF_F800;
    a.in_valid = 1'b0; a.instruction = '0; a.ImmSrc = '0; a.flush = 1'b0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.instruction = '0; b.ImmSrc = '0; b.flush = 1'b0; b.out_ready = 1'b0;

    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_valid", 64'(a.out_valid), 64'd0);
    chk("rst_ready", 64'(a.in_ready), 64'd1);
    chk("rst_imm", 64'(a.ImmExt), 64'd0);
    chk("rst_ill", 64'(a.out_illegal), 64'd0);

    // Format decode
    beat32("I", 25'h1FFE001, IMM_I, 32'hFFFFFFFF, 1'b0);
    beat32("S", 25'(32'hFE112E23 >> 7), IMM_S, 32'hFFFFFFFC, 1'b0);
    beat32("B", 25'(32'hFE000EE3 >> 7), IMM_B, 32'hFFFFFFFC, 1'b0);
    beat32("U", 25'(32'h123450B7 >> 7), IMM_U, 32'h12345000, 1'b0);
    beat32("J", 25'h1000000, IMM_J, 32'hFFF00000, 1'b0);
    beat32("ILL6", 25'h1FFFFFF, 3'b110, 32'h0, 1'b1);
    beat32("ILL7", 25'h1234567, 3'b111, 32'h0, 1'b1);
    beat32("Z", 25'h0001F00, IMM_Z, 32'h0000001F, 1'b0);

    // Backpressure: only two beats fit while the consumer stalls
    a.out_ready = 1'b0; a.ImmSrc = IMM_I; idx = 0;
    for (int c = 0; c < 4; c++) begin
      a.in_valid = 1'b1; a.instruction = {vals[idx][11:0], 13'h0};
      acc = a.in_ready;
      step();
      if (acc) idx++;
      if (c > 0) chk("bp_stall_imm", 64'(a.ImmExt), 64'(vals[0]));
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready", 64'(a.in_ready), 64'd0);
    chk("bp_valid", 64'(a.out_valid), 64'd1);

    a.out_ready = 1'b1; rcv = 0;
    for (int c = 0; c < 12 && rcv < 4; c++) begin
      if (idx < 4) begin
        a.in_valid = 1'b1; a.instruction = {vals[idx][11:0], 13'h0};
      end else begin
        a.in_valid = 1'b0;
      end
      acc = a.in_ready && a.in_valid; pop = a.out_valid; popv = a.ImmExt;
      step();
      if (acc) idx++;
      if (pop) begin
        chk("bp_order", 64'(popv), 64'(vals[rcv]));
        rcv++;
      end
    end
    a.in_valid = 1'b0;
    chk("bp_count", 64'(rcv), 64'd4);
    chk("bp_empty", 64'(a.out_valid), 64'd0);

    // Flush from FULL, then a flush-cycle beat must be dropped
    a.out_ready = 1'b0; a.in_valid = 1'b1; a.instruction = 25'h1FFE001; a.ImmSrc = IMM_I;
    step(); step();
    chk("fl_full", 64'(a.in_ready), 64'd0);
    a.flush = 1'b1;
    step();
    a.flush = 1'b0; a.in_valid = 1'b0;
    chk("fl_valid", 64'(a.out_valid), 64'd0);
    chk("fl_ready", 64'(a.in_ready), 64'd1);
    a.in_valid = 1'b1; a.flush = 1'b1;
    step();
    a.flush = 1'b0; a.in_valid = 1'b0;
    chk("fl_discard", 64'(a.out_valid), 64'd0);

    // Reset mid-stall with buffered illegal entries
    a.in_valid = 1'b1; a.ImmSrc = 3'b110;
    step(); step();
    chk("mr_pre_ill", 64'(a.out_illegal), 64'd1);
    reset = 1'b1; a.flush = 1'b1;
    step();
    reset = 1'b0; a.flush = 1'b0; a.in_valid = 1'b0;
    chk("mr_valid", 64'(a.out_valid), 64'd0);
    chk("mr_ready", 64'(a.in_ready), 64'd1);
    chk("mr_imm", 64'(a.ImmExt), 64'd0);
    chk("mr_ill", 64'(a.out_illegal), 64'd0);
    a.out_ready = 1'b1; a.ImmSrc = IMM_I;
    for (int k = 0; k < 4; k++) begin
      a.in_valid = 1'b1; a.instruction = {vals[k][11:0], 13'h0};
      step();
      chk("mr_resume_valid", 64'(a.out_valid), 64'd1);
      chk("mr_resume_imm", 64'(a.ImmExt), 64'(vals[k]));
    end
    a.in_valid = 1'b0;
    step();

    // XLEN=64, single-entry variant
    b.out_ready = 1'b1; b.in_valid = 1'b1; b.instruction = 25'h1FFE001; b.ImmSrc = IMM_I;
    step();
    chk("x64_I", b.ImmExt, 64'hFFFFFFFFFFFFFFFF);
    b.instruction = 25'h1000000; b.ImmSrc = IMM_U;
    step();
    chk("x64_U", b.ImmExt, 64'hFFFFFFFF80000000);
    b.in_valid = 1'b0; b.out_ready = 1'b0;
    #1;
    chk("x64_stall_ready", 64'(b.in_ready), 64'd0);
    b.out_ready = 1'b1;
    #1;
    chk("x64_pop_ready", 64'(b.in_ready), 64'd1);
    step();
    chk("x64_drain", 64'(b.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
